irq_gen: RTL and testbench

IRQ_GEN -- requirements
Module: irq_gen

---
 rtl/irq_gen.sv | 117 +++++++++++
 tb/tb_irq_gen.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_gen.sv
// Interrupt aggregator: per-source pending latch with edge/level capture, mask, and a hold-off counter that paces pulses.
// Define IRQ_GEN_SYNC_EN to insert a two-flop synchronizer on every dev_irq line.
`timescale 1ns/1ps
module irq_gen #(
    parameter int HOLD_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [30:1]       dev_irq,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_addr,
    input  logic [31:0]       cfg_wdata,
    output logic [31:0]       cfg_rdata,
    output logic [30:1]       ir_map
);

    localparam logic [1:0] ADDR_MASK = 2'd0;
    localparam logic [1:0] ADDR_EDGE = 2'd1;
    localparam logic [1:0] ADDR_PEND = 2'd2;
    localparam logic [1:0] ADDR_HOLD = 2'd3;

    function automatic logic [HOLD_W-1:0] sat_dec(input logic [HOLD_W-1:0] v);
        return (v == '0) ? v : v - {{(HOLD_W-1){1'b0}}, 1'b1};
    endfunction

    logic [30:1]       mask_q, mask_d;
    logic [30:1]       edge_en_q, edge_en_d;
    logic [30:1]       pend_q, pend_d;
    logic [30:1]       prev_q, prev_d;
    logic [30:1]       irmap_q, irmap_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic [30:1]       samp;
    logic [30:1]       set_cond;
    logic [30:1]       eligible;
    logic [30:1]       clr;
    logic              issue;
    logic              unused_wdata;

    assign unused_wdata = cfg_wdata[31];

`ifdef IRQ_GEN_SYNC_EN
    logic [30:1] sync1_q, sync2_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= dev_irq;
            sync2_q <= sync1_q;
        end
    end

    assign samp = sync2_q;
`else
    assign samp = dev_irq;
`endif

    always_comb begin
        set_cond  = (edge_en_q & samp & ~prev_q) | (~edge_en_q & samp);
        eligible  = pend_q & mask_q;
        issue     = (cnt_q == '0) && (|eligible);

        clr       = issue ? eligible : '0;
        mask_d    = mask_q;
        edge_en_d = edge_en_q;
        hold_d    = hold_q;
        if (cfg_we) begin
            case (cfg_addr)
                ADDR_MASK: mask_d    = cfg_wdata[30:1];
                ADDR_EDGE: edge_en_d = cfg_wdata[30:1];
                ADDR_PEND: clr       = clr | cfg_wdata[30:1];
                default:   hold_d    = cfg_wdata[HOLD_W-1:0];
            endcase
        end

        // A fresh set condition beats any clear on the same bit.
        pend_d  = (pend_q & ~clr) | set_cond;
        irmap_d = issue ? eligible : '0;
        cnt_d   = issue ? hold_q : sat_dec(cnt_q);
        prev_d  = samp;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mask_q    <= '0;
            edge_en_q <= '0;
            pend_q    <= '0;
            prev_q    <= '0;
            irmap_q   <= '0;
            hold_q    <= '0;
            cnt_q     <= '0;
        end else begin
            mask_q    <= mask_d;
            edge_en_q <= edge_en_d;
            pend_q    <= pend_d;
            prev_q    <= prev_d;
            irmap_q   <= irmap_d;
            hold_q    <= hold_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            ADDR_MASK: cfg_rdata = {1'b0, mask_q, 1'b0};
            ADDR_EDGE: cfg_rdata = {1'b0, edge_en_q, 1'b0};
            ADDR_PEND: cfg_rdata = {1'b0, pend_q, 1'b0};
            default:   cfg_rdata[HOLD_W-1:0] = hold_q;
        endcase
    end

    assign ir_map = irmap_q;

endmodule

// File: tb/tb_irq_gen.sv
// Scoreboard bench for irq_gen: expected pulses (edge index + value) are queued as stimulus is driven and
// matched against ir_map every cycle; register reads are checked inline.
`timescale 1ns/1ps
module tb_irq_gen;
  localparam int HOLD_W = 16;
`ifdef IRQ_GEN_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [30:1] dev_irq = '0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = 2'd0;
  logic [31:0] cfg_wdata = '0;
  logic [31:0] cfg_rdata;
  logic [30:1] ir_map;

  irq_gen #(.HOLD_W(HOLD_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .dev_irq   (dev_irq),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata),
    .ir_map    (ir_map)
  );

  always #10 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          at;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  logic [31:0] obs;
  always @(negedge clk) begin
    obs = {1'b0, ir_map, 1'b0};
    while (sb.size() > 0 && sb[0].at < edge_cnt) begin
      checks++;
      errors++;
      $display("FAIL pulse_missing edge %0d: got none, required %h", sb[0].at, sb[0].val);
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].at == edge_cnt) begin
      checks++;
      if (obs !== sb[0].val) begin
        errors++;
        $display("FAIL pulse edge %0d: ir_map=%h required %h", edge_cnt, obs, sb[0].val);
      end
      void'(sb.pop_front());
    end else if (obs !== 32'h0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_pulse edge %0d: ir_map=%h required 0", edge_cnt, obs);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int e);
    while (edge_cnt < e) tick(1);
  endtask

  task automatic push_pulse(input int at, input logic [31:0] v);
    exp_t e;
    e.at  = at;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic set_dev(input logic [31:0] w);
    dev_irq = w[30:1];
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    tick(1);
    cfg_we    = 1'b0;
    cfg_wdata = '0;
  endtask

  task automatic cfg_read(input logic [1:0] a, output logic [31:0] r);
    cfg_addr = a;
    #1;
    r = cfg_rdata;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    rst_n = 1'b0;
    tick(3);
    checks++;
    if (ir_map !== '0) begin
      errors++;
      $display("FAIL reset_ir_map: got %h required 0", ir_map);
    end
    for (int a = 0; a < 4; a++) begin
      cfg_read(2'(a), r);
      checks++;
      if (r !== 32'h0) begin
        errors++;
        $display("FAIL reset_reg%0d: got %h required 0", a, r);
      end
    end
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_regs();
    logic [31:0] r;
    cfg_write(2'd0, 32'hFFFF_FFFF);
    cfg_read(2'd0, r);
    checks++;
    if (r !== 32'h7FFF_FFFE) begin
      errors++;
      $display("FAIL reg_mask: got %h required 7ffffffe", r);
    end
    cfg_write(2'd1, 32'hA5A5_A5A5);
    cfg_read(2'd1, r);
    checks++;
    if (r !== 32'h25A5_A5A4) begin
      errors++;
      $display("FAIL reg_edge: got %h required 25a5a5a4", r);
    end
    cfg_write(2'd3, 32'hFFFF_FFFF);
    cfg_read(2'd3, r);
    checks++;
    if (r !== 32'h0000_FFFF) begin
      errors++;
      $display("FAIL reg_hold: got %h required 0000ffff", r);
    end
    cfg_write(2'd0, 32'h0);
    cfg_write(2'd1, 32'h0);
    cfg_write(2'd3, 32'h0);
    tick(2);
  endtask

  // One rising edge, held high, in edge mode: exactly one pulse.
  task automatic test_edge_single();
    logic [31:0] r;
    int c;
    cfg_write(2'd0, 32'h2);
    cfg_write(2'd1, 32'h2);
    cfg_write(2'd3, 32'h0);
    c = edge_cnt;
    push_pulse(c + LAT, 32'h2);
    set_dev(32'h2);
    tick(10);
    cfg_read(2'd2, r);
    checks++;
    if (r !== 32'h0) begin
      errors++;
      $display("FAIL edge_pend_after: got %h required 0", r);
    end
    set_dev(32'h0);
    tick(4);
  endtask

  // Level source with HOLD=0: a pulse on each consecutive cycle.
  task automatic test_back_to_back();
    int c;
    cfg_write(2'd0, 32'h10);
    cfg_write(2'd1, 32'h0);
    c = edge_cnt;
    for (int k = 0; k < 5; k++) push_pulse(c + LAT + k, 32'h10);
    set_dev(32'h10);
    tick(5);
    set_dev(32'h0);
    tick(8);
  endtask

  // Level source held 20 samples with HOLD=3: pulses HOLD+1 apart; the pend re-set during
  // the last hold-off still issues once after the source drops.
  task automatic test_level_holdoff();
    int c;
    int n;
    cfg_write(2'd0, 32'h8);
    cfg_write(2'd1, 32'h0);
    cfg_write(2'd3, 32'd3);
    tick(2);
    c = edge_cnt;
    for (int k = 0; k < 6; k++) push_pulse(c + LAT + 4 * k, 32'h8);
    set_dev(32'h8);
    wait_until(c + LAT - 1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ir_map[3]) n++;
      if (edge_cnt == c + 20) set_dev(32'h0);
    end
    checks++;
    if (n != 5) begin
      errors++;
      $display("FAIL level_pulse_count: got %0d required 5", n);
    end
    tick(10);
  endtask

  task automatic test_masked_pend();
    logic [31:0] r;
    int c;
    cfg_write(2'd0, 32'h0);
    cfg_write(2'd1, 32'h20);
    cfg_write(2'd3, 32'h0);
    cfg_write(2'd2, 32'hFFFF_FFFF);
    tick(4);
    set_dev(32'h20);
    tick(LAT + 2);
    cfg_read(2'd2, r);
    checks++;
    if (r !== 32'h20) begin
      errors++;
      $display("FAIL masked_pend: got %h required 00000020", r);
    end
    c = edge_cnt;
    push_pulse(c + 2, 32'h20);
    cfg_write(2'd0, 32'h20);
    tick(1);
    cfg_read(2'd2, r);
    checks++;
    if (r !== 32'h0) begin
      errors++;
      $display("FAIL unmask_pend_clear: got %h required 0", r);
    end
    set_dev(32'h0);
    tick(4);
  endtask

  task automatic test_w1c_race();
    logic [31:0] r;
    cfg_write(2'd0, 32'h0);
    tick(3);
    set_dev(32'h20);
    tick(LAT + 1);
    cfg_read(2'd2, r);
    checks++;
    if (r !== 32'h20) begin
      errors++;
      $display("FAIL race_setup_pend: got %h required 00000020", r);
    end
    set_dev(32'h0);
    tick(LAT + 1);
    set_dev(32'h20);
    tick(LAT - 2);
    cfg_write(2'd2, 32'h20);
    tick(1);
    cfg_read(2'd2, r);
    checks++;
    if (r !== 32'h20) begin
      errors++;
      $display("FAIL race_set_wins: got %h required 00000020", r);
    end
    cfg_write(2'd2, 32'h20);
    cfg_read(2'd2, r);
    checks++;
    if (r !== 32'h0) begin
      errors++;
      $display("FAIL w1c_clear: got %h required 0", r);
    end
    set_dev(32'h0);
    tick(4);
  endtask

  // HOLD=10 spacing; a HOLD rewrite mid hold-off only applies from the next issue.
  task automatic test_holdoff_spacing();
    int c;
    int p;
    cfg_write(2'd0, 32'h6);
    cfg_write(2'd1, 32'h6);
    cfg_write(2'd3, 32'd10);
    cfg_write(2'd2, 32'hFFFF_FFFF);
    tick(4);
    c = edge_cnt;
    p = c + LAT;
    push_pulse(p, 32'h2);
    push_pulse(p + 11, 32'h4);
    set_dev(32'h2);
    tick(2);
    set_dev(32'h6);
    wait_until(p + 2);
    cfg_write(2'd3, 32'd2);
    wait_until(p + 11);
    set_dev(32'h0);
    tick(1);
    push_pulse(p + 13 + LAT - 1, 32'h2);
    set_dev(32'h2);
    tick(LAT + 4);
    set_dev(32'h0);
    tick(4);
  endtask

  task automatic test_reset_midway();
    logic [31:0] r;
    int c;
    cfg_write(2'd3, 32'd10);
    tick(4);
    c = edge_cnt;
    push_pulse(c + LAT, 32'h2);
    set_dev(32'h2);
    tick(2);
    set_dev(32'h0);
    tick(1);
    set_dev(32'h6);
    tick(LAT + 1);
    cfg_read(2'd2, r);
    checks++;
    if (r !== 32'h6) begin
      errors++;
      $display("FAIL mid_pend_before_reset: got %h required 00000006", r);
    end
    set_dev(32'h0);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    checks++;
    if (ir_map !== '0) begin
      errors++;
      $display("FAIL mid_reset_ir_map: got %h required 0", ir_map);
    end
    for (int a = 0; a < 4; a++) begin
      cfg_read(2'(a), r);
      checks++;
      if (r !== 32'h0) begin
        errors++;
        $display("FAIL mid_reset_reg%0d: got %h required 0", a, r);
      end
    end
    tick(6);
    // A discarded hold-off counter lets a fresh level request through immediately.
    c = edge_cnt;
    push_pulse(c + LAT, 32'h2);
    set_dev(32'h2);
    cfg_write(2'd0, 32'h2);
    set_dev(32'h0);
    tick(8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_regs();
    test_edge_single();
    test_back_to_back();
    test_level_holdoff();
    test_masked_pend();
    test_w1c_race();
    test_holdoff_spacing();
    test_reset_midway();
    tick(20);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
